// File: rtl/led_mode_sequencer.sv
// LED bank controller: debounced pushbutton steps through four display patterns
// (bounce, binary count, blink, fill) advanced by a shared step prescaler.
module led_mode_sequencer #(
  parameter int CLK_HZ      = 27000000,
  parameter int NUM_LEDS    = 6,
  parameter int STEP_HZ     = 10,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                BTN,
  output logic [NUM_LEDS-1:0] LEDS,
  output logic [1:0]          MODE
);

  localparam int STEP_CYC = CLK_HZ / STEP_HZ;
  localparam int DB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DB_W     = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int STEP_W   = $clog2(STEP_CYC);

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYC - 1);
  localparam logic [NUM_LEDS-1:0] PAT_ZERO  = {NUM_LEDS{1'b0}};
  localparam logic [NUM_LEDS-1:0] PAT_ALL   = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] PAT_ONE   = NUM_LEDS'(1);
  localparam logic                DIR_LEFT  = 1'b0;
  localparam logic                DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    M_BOUNCE = 2'd0,
    M_COUNT  = 2'd1,
    M_BLINK  = 2'd2,
    M_FILL   = 2'd3
  } mode_e;

  logic                sync1_q, sync2_q;
  logic                stable_q, stable_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                press_q, press_d;
  logic [STEP_W-1:0]   pre_q, pre_d;
  logic                step_q, step_d;
  mode_e               mode_q, mode_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic                dir_q, dir_d;
  logic [NUM_LEDS-1:0] leds_q;

  // Debounce: the synchronized level must differ from the stable level for DB_CYC cycles.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = {DB_W{1'b0}};
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
  end

  // Step prescaler; a mode change restarts it and drops any pending step.
  always_comb begin
    pre_d  = pre_q;
    step_d = 1'b0;
    if (press_q) begin
      pre_d = {STEP_W{1'b0}};
    end else if (pre_q == STEP_LAST) begin
      pre_d  = {STEP_W{1'b0}};
      step_d = 1'b1;
    end else begin
      pre_d = pre_q + STEP_W'(1);
    end
  end

  // Mode FSM and pattern generators; a press takes priority over a step.
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    if (press_q) begin
      case (mode_q)
        M_BOUNCE: begin mode_d = M_COUNT;  pat_d = PAT_ZERO; end
        M_COUNT:  begin mode_d = M_BLINK;  pat_d = PAT_ALL;  end
        M_BLINK:  begin mode_d = M_FILL;   pat_d = PAT_ZERO; end
        M_FILL:   begin mode_d = M_BOUNCE; pat_d = PAT_ONE; dir_d = DIR_LEFT; end
        default:  begin mode_d = M_BOUNCE; pat_d = PAT_ONE; dir_d = DIR_LEFT; end
      endcase
    end else if (step_q) begin
      case (mode_q)
        M_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (pat_q[NUM_LEDS-1]) begin
              dir_d = DIR_RIGHT;
              pat_d = {1'b0, pat_q[NUM_LEDS-1:1]};
            end else begin
              pat_d = {pat_q[NUM_LEDS-2:0], 1'b0};
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DIR_LEFT;
              pat_d = {pat_q[NUM_LEDS-2:0], 1'b0};
            end else begin
              pat_d = {1'b0, pat_q[NUM_LEDS-1:1]};
            end
          end
        end
        M_COUNT:  pat_d = pat_q + NUM_LEDS'(1);
        M_BLINK:  pat_d = ~pat_q;
        M_FILL:   pat_d = (pat_q == PAT_ALL) ? PAT_ZERO : {pat_q[NUM_LEDS-2:0], 1'b1};
        default:  pat_d = pat_q;
      endcase
    end else begin
      pat_d = pat_q;
    end
  end

  // State registers; LEDS is registered directly from the next pattern.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      db_cnt_q <= {DB_W{1'b0}};
      press_q  <= 1'b0;
      pre_q    <= {STEP_W{1'b0}};
      step_q   <= 1'b0;
      mode_q   <= M_BOUNCE;
      pat_q    <= PAT_ONE;
      dir_q    <= DIR_LEFT;
      leds_q   <= ~PAT_ONE;
    end else begin
      sync1_q  <= BTN;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      pre_q    <= pre_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      dir_q    <= dir_d;
      leds_q   <= ~pat_d;
    end
  end

  assign LEDS = leds_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench: table of {BTN, cycles, expected LEDS/MODE} records feeding
// a scoreboard queue keyed by clock-edge number, plus a hand-written reset sequence.
module tb_led_mode_sequencer;

  logic       clk;
  logic       nrst;
  logic       btn;
  logic [5:0] leds;
  logic [1:0] mode;

  led_mode_sequencer #(
    .CLK_HZ(1000), .NUM_LEDS(6), .STEP_HZ(100), .DEBOUNCE_MS(4)
  ) dut (
    .CLK(clk), .nRST(nrst), .BTN(btn), .LEDS(leds), .MODE(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       btn;
    int         cycles;
    logic [5:0] leds;
    logic [1:0] mode;
  } vec_t;

  typedef struct {
    string      name;
    int         at;
    logic [5:0] leds;
    logic [1:0] mode;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   cyc;
  int   total;
  int   bad;

  task automatic add(input string n, input logic b, input int c,
                     input logic [5:0] l, input logic [1:0] m);
    vec_t v;
    v.name = n; v.btn = b; v.cycles = c; v.leds = l; v.mode = m;
    vq.push_back(v);
  endtask

  task automatic chk(input string n, input logic [5:0] l, input logic [1:0] m);
    total++;
    if (leds !== l || mode !== m) begin
      bad++;
      $display("FAIL %s @edge %0d: got LEDS=%b MODE=%0d, want LEDS=%b MODE=%0d",
               n, cyc, leds, mode, l, m);
    end
  endtask

  task automatic expect_at(input string n, input int at,
                           input logic [5:0] l, input logic [1:0] m);
    exp_t e;
    e.name = n; e.at = at; e.leds = l; e.mode = m;
    sb.push_back(e);
  endtask

  task automatic service();
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: check for edge %0d missed at edge %0d", e.name, e.at, cyc);
      end else begin
        chk(e.name, e.leds, e.mode);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    service();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    nrst  = 1'b0;
    btn   = 1'b1;

    // BOUNCE from reset: step k lands on edge 1+10k
    add("bnc_pre",    1'b1,  10, 6'b111110, 2'd0);
    add("bnc_s1",     1'b1,   1, 6'b111101, 2'd0);
    add("bnc_s5",     1'b1,  40, 6'b011111, 2'd0);
    add("bnc_s6",     1'b1,  10, 6'b101111, 2'd0);
    add("bnc_s10",    1'b1,  40, 6'b111110, 2'd0);
    // short glitch then a held press (mode change 7 edges after first low sample)
    add("glitch",     1'b0,   3, 6'b111110, 2'd0);
    add("glitch_end", 1'b1,   5, 6'b111110, 2'd0);
    add("press_pre",  1'b0,   6, 6'b111101, 2'd0);
    add("press",      1'b0,   1, 6'b111111, 2'd1);
    add("hold200",    1'b0, 200, 6'b101100, 2'd1);
    add("cnt63",      1'b1, 431, 6'b000000, 2'd1);
    add("cnt64",      1'b1,  10, 6'b111111, 2'd1);
    add("blink_pre",  1'b0,   6, 6'b111111, 2'd1);
    add("blink_in",   1'b0,   1, 6'b000000, 2'd2);
    add("blink_hold", 1'b1,  10, 6'b000000, 2'd2);
    add("blink_t1",   1'b1,   1, 6'b111111, 2'd2);
    add("blink_t2",   1'b1,  10, 6'b000000, 2'd2);
    add("fill_pre",   1'b0,   6, 6'b000000, 2'd2);
    add("to_fill",    1'b0,   1, 6'b111111, 2'd3);
    add("fill_rel",   1'b1,   8, 6'b111111, 2'd3);
    add("bnc_pre2",   1'b0,   6, 6'b111110, 2'd3);
    add("to_bounce",  1'b0,   1, 6'b111110, 2'd0);
    add("rel1",       1'b1,  10, 6'b111110, 2'd0);
    add("cnt_pre",    1'b0,   6, 6'b111101, 2'd0);
    add("to_cnt",     1'b0,   1, 6'b111111, 2'd1);
    add("rel2",       1'b1,  10, 6'b111111, 2'd1);
    add("blk_pre",    1'b0,   6, 6'b111110, 2'd1);
    add("to_blk",     1'b0,   1, 6'b000000, 2'd2);
    add("rel3",       1'b1,  14, 6'b111111, 2'd2);
    // press lands on the same edge as a BLINK step
    add("simul_pre",  1'b0,   6, 6'b111111, 2'd2);
    add("simul",      1'b0,   1, 6'b111111, 2'd3);
    add("fill_wait",  1'b1,  10, 6'b111111, 2'd3);
    add("fill1",      1'b1,   1, 6'b111110, 2'd3);
    add("fill2",      1'b1,  10, 6'b111100, 2'd3);
    add("fill3",      1'b1,  10, 6'b111000, 2'd3);
    add("fill4",      1'b1,  10, 6'b110000, 2'd3);
    add("fill5",      1'b1,  10, 6'b100000, 2'd3);
    add("fill6",      1'b1,  10, 6'b000000, 2'd3);
    add("fill7",      1'b1,  10, 6'b111111, 2'd3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_reset", 6'b111110, 2'd0);
    nrst = 1'b1;
    cyc  = 0;
    #1;
    chk("reset_release", 6'b111110, 2'd0);

    foreach (vq[i]) begin
      btn = vq[i].btn;
      expect_at(vq[i].name, cyc + vq[i].cycles, vq[i].leds, vq[i].mode);
      for (int k = 0; k < vq[i].cycles; k++) tick();
    end

    // asynchronous reset between edges while BTN is held low
    btn = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst", 6'b111110, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    cyc  = 0;
    expect_at("post_rst_pre",   6, 6'b111110, 2'd0);
    expect_at("post_rst_press", 7, 6'b111111, 2'd1);
    expect_at("post_rst_cnt",  40, 6'b111100, 2'd1);
    for (int k = 0; k < 40; k++) tick();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
